icache_linefill_responder: RTL and testbench

Downstream-side responder for I-cache line fills. It accepts miss requests from the I-cache MSHR and queues them in a small FIFO. For each request it fetches one full cache line from a beat-wide memory port and assembles the beats into a line. It returns the line on the `downstream_rxdat` channel together with the echoed entry index, txnid, `lineA` flag and opcode, and so forms the far end of the channel consumed by the I-cache data-array controller.

---
 rtl/icache_linefill_responder_if.sv | 50 +++++
 rtl/icache_linefill_responder.sv | 154 +++++++++++++++
 tb/tb_icache_linefill_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_linefill_responder_if.sv
// Channel bundle for the I-cache line-fill responder: miss requests in, memory beats, line responses out.
// slave is the responder's view; master is the view of the surrounding MSHR, memory and consumer.
interface icache_linefill_responder_if #(
    parameter int DATA_WIDTH      = 256,
    parameter int BEAT_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int TXNID_WIDTH     = 5,
    parameter int ENTRY_IDX_WIDTH = 3,
    parameter int OPCODE_WIDTH    = 2
);
    logic                       downstream_txreq_vld;
    logic                       downstream_txreq_rdy;
    logic [ADDR_WIDTH-1:0]      downstream_txreq_addr;
    logic [TXNID_WIDTH-1:0]     downstream_txreq_txnid;
    logic [ENTRY_IDX_WIDTH-1:0] downstream_txreq_entry_idx;
    logic                       downstream_txreq_lineA;
    logic [OPCODE_WIDTH-1:0]    downstream_txreq_opcode;

    logic                       mem_req_vld;
    logic                       mem_req_rdy;
    logic [ADDR_WIDTH-1:0]      mem_req_addr;
    logic                       mem_rsp_vld;
    logic [BEAT_WIDTH-1:0]      mem_rsp_data;

    logic                       downstream_rxdat_vld;
    logic                       downstream_rxdat_rdy;
    logic [DATA_WIDTH-1:0]      downstream_rxdat_data;
    logic [TXNID_WIDTH-1:0]     downstream_rxdat_txnid;
    logic [ENTRY_IDX_WIDTH-1:0] downstream_rxdat_entry_idx;
    logic                       downstream_rxdat_lineA;
    logic [OPCODE_WIDTH-1:0]    downstream_rxdat_opcode;

    modport slave (
        input  downstream_txreq_vld, downstream_txreq_addr, downstream_txreq_txnid,
               downstream_txreq_entry_idx, downstream_txreq_lineA, downstream_txreq_opcode,
               mem_req_rdy, mem_rsp_vld, mem_rsp_data, downstream_rxdat_rdy,
        output downstream_txreq_rdy, mem_req_vld, mem_req_addr,
               downstream_rxdat_vld, downstream_rxdat_data, downstream_rxdat_txnid,
               downstream_rxdat_entry_idx, downstream_rxdat_lineA, downstream_rxdat_opcode
    );

    modport master (
        output downstream_txreq_vld, downstream_txreq_addr, downstream_txreq_txnid,
               downstream_txreq_entry_idx, downstream_txreq_lineA, downstream_txreq_opcode,
               mem_req_rdy, mem_rsp_vld, mem_rsp_data, downstream_rxdat_rdy,
        input  downstream_txreq_rdy, mem_req_vld, mem_req_addr,
               downstream_rxdat_vld, downstream_rxdat_data, downstream_rxdat_txnid,
               downstream_rxdat_entry_idx, downstream_rxdat_lineA, downstream_rxdat_opcode
    );
endinterface

// File: rtl/icache_linefill_responder.sv
// Queues I-cache miss requests, fetches each line beat by beat from memory and returns the assembled line.
// Optional ICACHE_LINEFILL_B2B_EN: go straight from RESP to the next FILL when another request is queued.
module icache_linefill_responder #(
    parameter int DATA_WIDTH      = 256,
    parameter int BEAT_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int TXNID_WIDTH     = 5,
    parameter int ENTRY_IDX_WIDTH = 3,
    parameter int OPCODE_WIDTH    = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input logic                        clk,
    input logic                        rst_n,
    icache_linefill_responder_if.slave bus
);
    localparam int BEATS      = DATA_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEATS) + 1;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W      = $clog2(FIFO_DEPTH);
    localparam int LINE_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]      fifo_addr  [FIFO_DEPTH];
    logic [TXNID_WIDTH-1:0]     fifo_txnid [FIFO_DEPTH];
    logic [ENTRY_IDX_WIDTH-1:0] fifo_entry [FIFO_DEPTH];
    logic                       fifo_linea [FIFO_DEPTH];
    logic [OPCODE_WIDTH-1:0]    fifo_opcode[FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [IDX_W-1:0] head_idx;
    logic             fifo_full, fifo_empty, push, pop, start_fill, mem_req_fire;

    logic [CNT_W-1:0]                  issue_cnt, rsp_cnt;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]  line_buf;
    logic [ADDR_WIDTH-1:0]             line_base;
    logic [TXNID_WIDTH-1:0]            cur_txnid;
    logic [ENTRY_IDX_WIDTH-1:0]        cur_entry;
    logic                              cur_linea;
    logic [OPCODE_WIDTH-1:0]           cur_opcode;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign push       = bus.downstream_txreq_vld && !fifo_full;
    assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign head_idx   = rd_ptr_nxt[IDX_W-1:0];

`ifdef ICACHE_LINEFILL_B2B_EN
    logic [PTR_W-1:0] fifo_count;
    assign fifo_count = wr_ptr - rd_ptr;
`endif

    assign bus.downstream_txreq_rdy = !fifo_full;
    assign bus.mem_req_vld          = (state_q == FILL) && (issue_cnt < CNT_W'(BEATS));
    assign bus.mem_req_addr         = line_base + (ADDR_WIDTH'(issue_cnt) << BEAT_SHIFT);
    assign mem_req_fire             = bus.mem_req_vld && bus.mem_req_rdy;

    assign bus.downstream_rxdat_vld       = (state_q == RESP);
    assign bus.downstream_rxdat_data      = line_buf;
    assign bus.downstream_rxdat_txnid     = cur_txnid;
    assign bus.downstream_rxdat_entry_idx = cur_entry;
    assign bus.downstream_rxdat_lineA     = cur_linea;
    assign bus.downstream_rxdat_opcode    = cur_opcode;

    always_comb begin
        state_d    = state_q;
        start_fill = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = FILL;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                if (bus.mem_rsp_vld && rsp_cnt == CNT_W'(BEATS - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.downstream_rxdat_rdy) begin
                    pop     = 1'b1;
                    state_d = IDLE;
`ifdef ICACHE_LINEFILL_B2B_EN
                    // A request pushed this very cycle is not yet readable, so it waits for IDLE.
                    if (fifo_count > PTR_W'(1)) begin
                        state_d    = FILL;
                        start_fill = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr  [wr_ptr[IDX_W-1:0]] <= bus.downstream_txreq_addr;
            fifo_txnid [wr_ptr[IDX_W-1:0]] <= bus.downstream_txreq_txnid;
            fifo_entry [wr_ptr[IDX_W-1:0]] <= bus.downstream_txreq_entry_idx;
            fifo_linea [wr_ptr[IDX_W-1:0]] <= bus.downstream_txreq_lineA;
            fifo_opcode[wr_ptr[IDX_W-1:0]] <= bus.downstream_txreq_opcode;
        end
    end

    // The head request is latched at fill start, so the response fields stay put while the FIFO moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            issue_cnt  <= '0;
            rsp_cnt    <= '0;
            line_buf   <= '0;
            line_base  <= '0;
            cur_txnid  <= '0;
            cur_entry  <= '0;
            cur_linea  <= 1'b0;
            cur_opcode <= '0;
        end else begin
            state_q <= state_d;
            rd_ptr  <= rd_ptr_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (start_fill) begin
                issue_cnt  <= '0;
                rsp_cnt    <= '0;
                line_buf   <= '0;
                line_base  <= fifo_addr[head_idx] & ~ADDR_WIDTH'(LINE_BYTES - 1);
                cur_txnid  <= fifo_txnid[head_idx];
                cur_entry  <= fifo_entry[head_idx];
                cur_linea  <= fifo_linea[head_idx];
                cur_opcode <= fifo_opcode[head_idx];
            end else if (state_q == FILL) begin
                if (mem_req_fire) begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                end
                if (bus.mem_rsp_vld) begin
                    line_buf[rsp_cnt[BEAT_IDX_W-1:0]] <= bus.mem_rsp_data;
                    rsp_cnt                           <= rsp_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_icache_linefill_responder.sv
// Scoreboard bench for icache_linefill_responder: a memory model answers beat reads, a monitor checks every output.
module tb_icache_linefill_responder;
    localparam int DATA_WIDTH      = 256;
    localparam int BEAT_WIDTH      = 64;
    localparam int ADDR_WIDTH      = 32;
    localparam int TXNID_WIDTH     = 5;
    localparam int ENTRY_IDX_WIDTH = 3;
    localparam int OPCODE_WIDTH    = 2;
    localparam int FIFO_DEPTH      = 4;
    localparam int BEATS           = DATA_WIDTH / BEAT_WIDTH;
    localparam int BEAT_BYTES      = BEAT_WIDTH / 8;
    localparam int LINE_BYTES      = DATA_WIDTH / 8;
`ifdef ICACHE_LINEFILL_B2B_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 2;
`endif

    typedef struct {
        logic [DATA_WIDTH-1:0]      data;
        logic [TXNID_WIDTH-1:0]     txnid;
        logic [ENTRY_IDX_WIDTH-1:0] entry;
        logic                       linea;
        logic [OPCODE_WIDTH-1:0]    opcode;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    icache_linefill_responder_if #(
        .DATA_WIDTH(DATA_WIDTH), .BEAT_WIDTH(BEAT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .TXNID_WIDTH(TXNID_WIDTH), .ENTRY_IDX_WIDTH(ENTRY_IDX_WIDTH), .OPCODE_WIDTH(OPCODE_WIDTH)
    ) bus ();

    icache_linefill_responder #(
        .DATA_WIDTH(DATA_WIDTH), .BEAT_WIDTH(BEAT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .TXNID_WIDTH(TXNID_WIDTH), .ENTRY_IDX_WIDTH(ENTRY_IDX_WIDTH), .OPCODE_WIDTH(OPCODE_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    resp_t                 exp_resp[$];
    logic [ADDR_WIDTH-1:0] exp_addr[$];
    logic [ADDR_WIDTH-1:0] pend_addr[$];
    int                    pend_ready[$];

    int checks = 0, errors = 0, cyc = 0, outstanding = 0;
    int rdy_mode = 0, rsp_mode = 0, sink_mode = 0, rsp_count = 0;
    int rx_rise_cyc = -1, last_rx_hs_cyc = -1, gap_meas = -1;
    bit gap_armed = 1'b0, prev_rx_vld = 1'b0, inject_spurious = 1'b0;
    resp_t mon_r;

    always @(posedge clk) cyc++;

    // Memory contents are a fixed scramble of the beat address.
    function automatic logic [BEAT_WIDTH-1:0] beat_fn(input logic [ADDR_WIDTH-1:0] a);
        return {a ^ 32'hC3A5_5A3C, a * 32'h9E37_79B1};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] line_of(input logic [ADDR_WIDTH-1:0] a);
        return a - ADDR_WIDTH'(a % LINE_BYTES);
    endfunction

    function automatic resp_t model_resp(input logic [ADDR_WIDTH-1:0] a, input logic [TXNID_WIDTH-1:0] t,
                                         input logic [ENTRY_IDX_WIDTH-1:0] e, input logic la,
                                         input logic [OPCODE_WIDTH-1:0] op);
        resp_t r;
        r.data = '0;
        for (int k = 0; k < BEATS; k++)
            r.data[k*BEAT_WIDTH +: BEAT_WIDTH] = beat_fn(line_of(a) + ADDR_WIDTH'(k * BEAT_BYTES));
        r.txnid  = t;
        r.entry  = e;
        r.linea  = la;
        r.opcode = op;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_WIDTH-1:0] actual,
                               input logic [DATA_WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNote(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_txreq_rdy"}, bus.downstream_txreq_rdy, 1'b1);
        checkOutput({tag, "_mem_req_vld"}, bus.mem_req_vld, 1'b0);
        checkOutput({tag, "_mem_req_addr"}, bus.mem_req_addr, '0);
        checkOutput({tag, "_rxdat_vld"}, bus.downstream_rxdat_vld, 1'b0);
        checkOutput({tag, "_rxdat_data"}, bus.downstream_rxdat_data, '0);
        checkOutput({tag, "_rxdat_txnid"}, bus.downstream_rxdat_txnid, '0);
        checkOutput({tag, "_rxdat_entry"}, bus.downstream_rxdat_entry_idx, '0);
        checkOutput({tag, "_rxdat_lineA"}, bus.downstream_rxdat_lineA, 1'b0);
        checkOutput({tag, "_rxdat_opcode"}, bus.downstream_rxdat_opcode, '0);
    endtask

    // Memory model: accepts beat reads per rdy_mode and answers in order, no earlier than one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_req_rdy  = 1'b0;
            bus.mem_rsp_vld  = 1'b0;
            bus.mem_rsp_data = '0;
        end else begin
            bus.mem_rsp_vld = 1'b0;
            if (pend_addr.size() > 0 && pend_ready[0] <= cyc &&
                (rsp_mode == 0 || $urandom_range(0, 1) == 1)) begin
                bus.mem_rsp_vld  = 1'b1;
                bus.mem_rsp_data = beat_fn(pend_addr.pop_front());
                void'(pend_ready.pop_front());
                rsp_count++;
            end else if (inject_spurious) begin
                bus.mem_rsp_vld  = 1'b1;
                bus.mem_rsp_data = {$urandom, $urandom};
                inject_spurious  = 1'b0;
            end
            case (rdy_mode)
                0:       bus.mem_req_rdy = 1'b1;
                1:       bus.mem_req_rdy = !bus.mem_req_rdy;
                default: bus.mem_req_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        case (sink_mode)
            0:       bus.downstream_rxdat_rdy = 1'b1;
            1:       bus.downstream_rxdat_rdy = 1'($urandom_range(0, 1));
            default: bus.downstream_rxdat_rdy = 1'b0;
        endcase
    end

    // Monitor: samples settled values mid-cycle, compares against the scoreboard queues.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_rx_vld = 1'b0;
        end else begin
            checkOutput("txreq_rdy", bus.downstream_txreq_rdy, outstanding < FIFO_DEPTH);
            if (bus.downstream_txreq_vld && bus.downstream_txreq_rdy) begin
                exp_resp.push_back(model_resp(bus.downstream_txreq_addr, bus.downstream_txreq_txnid,
                                              bus.downstream_txreq_entry_idx, bus.downstream_txreq_lineA,
                                              bus.downstream_txreq_opcode));
                for (int k = 0; k < BEATS; k++)
                    exp_addr.push_back(line_of(bus.downstream_txreq_addr) + ADDR_WIDTH'(k * BEAT_BYTES));
                outstanding++;
            end
            if (bus.mem_req_vld) begin
                if (exp_addr.size() == 0) begin
                    failNote("mem_req_unexpected");
                end else begin
                    checkOutput("mem_req_addr", bus.mem_req_addr, exp_addr[0]);
                    if (bus.mem_req_rdy) begin
                        void'(exp_addr.pop_front());
                        pend_addr.push_back(bus.mem_req_addr);
                        pend_ready.push_back(cyc + 1);
                        if (gap_armed) begin
                            gap_meas  = cyc - last_rx_hs_cyc;
                            gap_armed = 1'b0;
                        end
                    end
                end
            end
            if (bus.downstream_rxdat_vld) begin
                if (!prev_rx_vld) rx_rise_cyc = cyc;
                if (exp_resp.size() == 0) begin
                    failNote("rxdat_unexpected");
                end else begin
                    mon_r = exp_resp[0];
                    checkOutput("rxdat_data", bus.downstream_rxdat_data, mon_r.data);
                    checkOutput("rxdat_txnid", bus.downstream_rxdat_txnid, mon_r.txnid);
                    checkOutput("rxdat_entry", bus.downstream_rxdat_entry_idx, mon_r.entry);
                    checkOutput("rxdat_lineA", bus.downstream_rxdat_lineA, mon_r.linea);
                    checkOutput("rxdat_opcode", bus.downstream_rxdat_opcode, mon_r.opcode);
                    if (bus.downstream_rxdat_rdy) begin
                        void'(exp_resp.pop_front());
                        outstanding--;
                        last_rx_hs_cyc = cyc;
                        gap_armed      = 1'b1;
                    end
                end
            end
            prev_rx_vld = bus.downstream_rxdat_vld;
        end
    end

    task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] a, input logic [TXNID_WIDTH-1:0] t,
                                 input logic [ENTRY_IDX_WIDTH-1:0] e, input logic la,
                                 input logic [OPCODE_WIDTH-1:0] op, output int acc_cyc);
        bit done = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            bus.downstream_txreq_vld       = 1'b1;
            bus.downstream_txreq_addr      = a;
            bus.downstream_txreq_txnid     = t;
            bus.downstream_txreq_entry_idx = e;
            bus.downstream_txreq_lineA     = la;
            bus.downstream_txreq_opcode    = op;
            #2;
            if (bus.downstream_txreq_rdy) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!done) failNote("txreq_accept_timeout");
        @(negedge clk);
        bus.downstream_txreq_vld = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        @(negedge clk); #3;
        while ((exp_resp.size() != 0 || outstanding != 0) && n < budget) begin
            @(negedge clk); #3;
            n++;
        end
        if (n >= budget) failNote(name);
    endtask

    task automatic waitRxVld(input string name, input int budget);
        int n = 0;
        @(negedge clk); #3;
        while (!bus.downstream_rxdat_vld && n < budget) begin
            @(negedge clk); #3;
            n++;
        end
        if (n >= budget) failNote(name);
    endtask

    task automatic randomRequest(output int acc_cyc);
        applyStimulus($urandom, TXNID_WIDTH'($urandom), ENTRY_IDX_WIDTH'($urandom), 1'($urandom),
                      OPCODE_WIDTH'($urandom), acc_cyc);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, acc5, base_cnt, n;
        bus.downstream_txreq_vld       = 1'b0;
        bus.downstream_txreq_addr      = '0;
        bus.downstream_txreq_txnid     = '0;
        bus.downstream_txreq_entry_idx = '0;
        bus.downstream_txreq_lineA     = 1'b0;
        bus.downstream_txreq_opcode    = '0;
        bus.mem_req_rdy                = 1'b0;
        bus.mem_rsp_vld                = 1'b0;
        bus.mem_rsp_data               = '0;
        bus.downstream_rxdat_rdy       = 1'b0;

        repeat (3) @(negedge clk);
        #3;
        checkResetValues("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: base 0x1000_0020 (offset bits below the 32-byte line dropped), latency 3+BEATS.
        $display("[TB] single request");
        applyStimulus(32'h1000_0024, 5'd3, 3'd2, 1'b1, 2'd1, acc);
        waitDrain("single_drain", 200);
        checkOutput("single_latency", rx_rise_cyc - acc, 3 + BEATS);

        // FIFO full: 4 accepted, 5th waits until the cycle after the first pop; rxdat held 10 cycles.
        $display("[TB] fifo full and held response");
        sink_mode = 2;
        for (int i = 0; i < FIFO_DEPTH; i++) randomRequest(acc);
        fork
            applyStimulus(32'h2000_0040, 5'd9, 3'd5, 1'b0, 2'd2, acc5);
        join_none
        waitRxVld("full_rx_wait", 200);
        checkOutput("full_txreq_rdy_low", bus.downstream_txreq_rdy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) inject_spurious = 1'b1;
        end
        sink_mode = 0;
        wait fork;
        checkOutput("fifth_accept_after_pop", acc5 - last_rx_hs_cyc, 1);
        waitDrain("full_drain", 1000);

        // Toggling mem_req_rdy with randomly delayed, interleaved beat responses.
        $display("[TB] toggling memory ready");
        rdy_mode = 1;
        rsp_mode = 1;
        randomRequest(acc);
        randomRequest(acc);
        waitDrain("toggle_drain", 1000);
        rdy_mode = 0;
        rsp_mode = 0;

        // Reset in the middle of a fill after two beats have landed.
        $display("[TB] reset mid-fill");
        base_cnt = rsp_count;
        applyStimulus(32'h3000_1234, 5'd17, 3'd6, 1'b1, 2'd3, acc);
        n = 0;
        while (rsp_count - base_cnt < 2 && n < 100) begin
            @(negedge clk); #3;
            n++;
        end
        if (n >= 100) failNote("midfill_beat_wait");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midfill");
        exp_resp.delete();
        exp_addr.delete();
        pend_addr.delete();
        pend_ready.delete();
        outstanding = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h3000_5678, 5'd21, 3'd1, 1'b0, 2'd2, acc);
        waitDrain("after_reset_drain", 200);

        // Two queued lines: gap from response handshake to the next line's first beat request.
        $display("[TB] back-to-back gap");
        sink_mode = 2;
        gap_meas  = -1;
        applyStimulus(32'h4000_0000, 5'd1, 3'd0, 1'b0, 2'd0, acc);
        applyStimulus(32'h4000_0100, 5'd2, 3'd1, 1'b1, 2'd1, acc);
        waitRxVld("gap_rx_wait", 200);
        sink_mode = 0;
        waitDrain("gap_drain", 400);
        checkOutput("b2b_gap", gap_meas, EXP_GAP);

        // Randomized traffic with random memory and consumer backpressure.
        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            rdy_mode  = $urandom_range(0, 2);
            rsp_mode  = $urandom_range(0, 1);
            sink_mode = $urandom_range(0, 1);
            randomRequest(acc);
        end
        sink_mode = 0;
        waitDrain("random_drain", 5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
